// File: rtl/parity_counter_ctrl.sv
// -----------------------------------------------------------------------------
// parity_counter_ctrl
// Front-panel controller for the 3-bit parity counter. Each of the three raw
// push-buttons passes through a 2-flop synchroniser, a debouncer and a
// rising-edge detector. The resulting press events drive the count-mode FSM
// (ALL -> EVEN -> ODD -> ALL), toggle pause, and request counter clears.
// A prescaler produces the counter step strobe.
//
// Ports
//   CLK        in   system clock, all state on rising edge
//   RESET_N    in   asynchronous active-low reset
//   BTN_MODE   in   raw button, 1 = pressed; each press advances the mode
//   BTN_PAUSE  in   raw button, 1 = pressed; each press toggles pause
//   BTN_CLEAR  in   raw button, 1 = pressed; each press clears the counter
//   TICK       out  one-cycle step strobe (counter clock-enable)
//   EVEN       out  even-only counting
//   ODD        out  odd-only counting
//   PAUSE      out  hold counter value (level)
//   RESET      out  synchronous counter clear, active-high
//   MODE       out  status: 00 ALL, 01 EVEN, 10 ODD
// -----------------------------------------------------------------------------
module parity_counter_ctrl #(
  parameter int TICK_DIV = 4,  // CLK cycles per counter step (>= 1)
  parameter int DB_LEN   = 3   // stable synchronised samples to accept a level (>= 1)
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BTN_MODE,
  input  logic       BTN_PAUSE,
  input  logic       BTN_CLEAR,
  output logic       TICK,
  output logic       EVEN,
  output logic       ODD,
  output logic       PAUSE,
  output logic       RESET,
  output logic [1:0] MODE
);

  typedef enum logic [1:0] {
    MODE_ALL  = 2'b00,
    MODE_EVEN = 2'b01,
    MODE_ODD  = 2'b10
  } mode_e;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DB_LEN + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_LEN - 1);

  localparam int B_MODE  = 0;
  localparam int B_PAUSE = 1;
  localparam int B_CLEAR = 2;

  // ---------------------------------------------------------------------------
  // Button conditioning: synchronise, debounce, detect accepted 0->1
  // ---------------------------------------------------------------------------
  logic [2:0]    btn_raw;
  logic [2:0]    sync_a, sync_b;
  logic [2:0]    level, level_d;
  logic [2:0]    press;
  logic [CW-1:0] db_cnt [3];

  assign btn_raw = {BTN_CLEAR, BTN_PAUSE, BTN_MODE};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      // NOTE: the debounce counters are a handful of flops, not a RAM, so they
      // take the async reset like the rest of the state.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync_a  <= btn_raw;
      sync_b  <= sync_a;
      level_d <= level;
      // Registered edge detect: a press is a single-cycle pulse, and a release
      // (1->0 of the accepted level) never produces one.
      press   <= level & ~level_d;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // DB_LEN-th consecutive differing sample: accept the new level.
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM, pause, clear and prescaler
  // ---------------------------------------------------------------------------
  mode_e         mode_q, mode_n;
  logic          pause_q, pause_n;
  logic          clr_q, clr_n;
  logic [PW-1:0] presc_q, presc_n;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q  <= MODE_ALL;
      pause_q <= 1'b0;
      clr_q   <= 1'b1;  // counter held clear until the first edge after release
      presc_q <= '0;
    end else begin
      mode_q  <= mode_n;
      pause_q <= pause_n;
      clr_q   <= clr_n;
      presc_q <= presc_n;
    end
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mode_n  = mode_q;
    pause_n = pause_q ^ press[B_PAUSE];
    clr_n   = press[B_CLEAR];
    presc_n = presc_q;

    // A mode change and a clear in the same cycle merge into one clear pulse.
    case (mode_q)
      MODE_ALL: begin
        if (press[B_MODE]) begin
          mode_n = MODE_EVEN;
          clr_n  = 1'b1;
        end
      end
      MODE_EVEN: begin
        if (press[B_MODE]) begin
          mode_n = MODE_ODD;
          clr_n  = 1'b1;
        end
      end
      MODE_ODD: begin
        if (press[B_MODE]) begin
          mode_n = MODE_ALL;
          clr_n  = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: recover to ALL and clear the counter.
        mode_n = MODE_ALL;
        clr_n  = 1'b1;
      end
    endcase

    // Prescaler is zero in the clear cycle; frozen (not restarted) while paused.
    if (clr_n) begin
      presc_n = '0;
    end else if (!pause_q) begin
      presc_n = (presc_q == TICK_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  assign TICK  = !clr_q && !pause_q && (presc_q == TICK_LAST);
  assign EVEN  = (mode_q == MODE_EVEN);
  assign ODD   = (mode_q == MODE_ODD);
  assign PAUSE = pause_q;
  assign RESET = clr_q;
  assign MODE  = mode_q;

endmodule
